// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the clk_divide_n divider.
// Behaviour of clamp_div depends on the optional macro CLKDIV_BYPASS_EN
// (divide-by-1 bypass); without it a requested divisor of 1 becomes 2.
`timescale 1ns/1ps
package clk_div_pkg;

   localparam int DIV_W_DEF = 8;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // Legalise a requested divisor: 0 means "reject the load".
   function automatic int unsigned clamp_div(input int unsigned d);
      int unsigned r;
      if (d == 32'd0) begin
         r = 32'd0;
      end else if (d == 32'd1) begin
`ifdef CLKDIV_BYPASS_EN
         r = 32'd1;
`else
         r = 32'd2;
`endif
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Number of full clk cycles p_q stays high: N/2 (even) or (N-1)/2 (odd).
   function automatic int unsigned half_period(input int unsigned n);
      int unsigned h;
      if (n[0] == 1'b1) begin
         h = (n - 32'd1) >> 1;
      end else begin
         h = n >> 1;
      end
      return h;
   endfunction

endpackage

// File: rtl/clk_div_oddext.sv
// clk_div_oddext: negedge half-cycle extension and output stage of the divider.
// All falling-edge logic lives here. With CLKDIV_BYPASS_EN defined a
// negedge-updated bypass flop selects the raw clock for divide-by-1.
`timescale 1ns/1ps
module clk_div_oddext (
   input  logic clk,
   input  logic rst_n,
   input  logic p_i,
   input  logic odd_i,
`ifdef CLKDIV_BYPASS_EN
   input  logic byp_i,
`endif
   output logic clk_o
);

   logic n_d;
   logic n_q;

   // Extension only applies to odd divisors; even divisors keep it cleared.
   always_comb begin
      n_d = 1'b0;
      if (odd_i) begin
         n_d = p_i;
      end else begin
         n_d = 1'b0;
      end
   end

   // Resample the posedge phase half a cycle later.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= 1'b0;
      end else begin
         n_q <= n_d;
      end
   end

`ifdef CLKDIV_BYPASS_EN
   logic byp_d;
   logic byp_q;

   // Bypass request is only ever taken while clk is low.
   always_comb begin
      byp_d = byp_i;
   end

   // Switch between raw clock and divided phase on the falling edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_q <= 1'b0;
      end else begin
         byp_q <= byp_d;
      end
   end

   // In bypass the divided path is held low, so the OR is glitch-free.
   always_comb begin
      clk_o = (clk & byp_q) | (~byp_q & (p_i | n_q));
   end
`else
   // Divided clock: posedge phase stretched by the negedge copy.
   always_comb begin
      clk_o = p_i | n_q;
   end
`endif

endmodule

// File: rtl/clk_divide_n.sv
// clk_divide_n: programmable 50% duty integer clock divider with enable,
// glitch-free divisor reload at period boundaries and a period-start tick.
// Optional macro CLKDIV_BYPASS_EN enables divide-by-1 (raw clock pass-through).
`timescale 1ns/1ps
module clk_divide_n
   import clk_div_pkg::*;
#(
   parameter int DIV_W    = DIV_W_DEF,
   parameter int DIV_INIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_load,
   output logic             div_busy,
   output logic             clk_o,
   output logic             tick_o
);

   run_state_e       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             p_q, p_d;
   logic             tick_q, tick_d;

   logic [DIV_W-1:0] ld_val_s;
   logic             ld_ok_s;
   logic             wrap_s;
   logic [DIV_W-1:0] next_div_s;

   // Next-state: counter, run/stop, divisor application, phase and tick.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      p_d        = p_q;
      tick_d     = 1'b0;
      ld_val_s   = DIV_W'(clamp_div(32'(div_i)));
      ld_ok_s    = div_load && (ld_val_s != '0);
      wrap_s     = (cnt_q == (div_q - DIV_W'(1)));
      next_div_s = busy_q ? pend_q : div_q;

      case (state_q)
         ST_STOP: begin
            if (en) begin
               // Start from stopped is a boundary: pending divisor applies.
               state_d = ST_RUN;
               div_d   = next_div_s;
               busy_d  = 1'b0;
               cnt_d   = '0;
               p_d     = (half_period(32'(next_div_s)) != 32'd0);
               tick_d  = 1'b1;
            end else begin
               cnt_d   = '0;
               p_d     = 1'b0;
               tick_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (wrap_s) begin
               div_d  = next_div_s;
               busy_d = 1'b0;
               cnt_d  = '0;
               if (en) begin
                  state_d = ST_RUN;
                  p_d     = (half_period(32'(next_div_s)) != 32'd0);
                  tick_d  = 1'b1;
               end else begin
                  // Park after a complete period.
                  state_d = ST_STOP;
                  p_d     = 1'b0;
                  tick_d  = 1'b0;
               end
            end else begin
               cnt_d  = cnt_q + DIV_W'(1);
               p_d    = (32'(cnt_q + DIV_W'(1)) < half_period(32'(div_q)));
               tick_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_STOP;
            cnt_d   = '0;
            p_d     = 1'b0;
            tick_d  = 1'b0;
         end
      endcase

      // A load on a boundary edge lands in pending for the following boundary.
      if (ld_ok_s) begin
         pend_d = ld_val_s;
         busy_d = 1'b1;
      end else begin
         pend_d = pend_q;
      end
   end

   // Posedge state registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         div_q   <= DIV_W'(DIV_INIT);
         pend_q  <= '0;
         busy_q  <= 1'b0;
         p_q     <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         p_q     <= p_d;
         tick_q  <= tick_d;
      end
   end

`ifdef CLKDIV_BYPASS_EN
   logic byp_next_s;

   // Bypass is wanted when the upcoming cycle runs with a divisor of 1.
   always_comb begin
      byp_next_s = (state_d == ST_RUN) && (div_d == DIV_W'(1));
   end
`endif

   clk_div_oddext u_oddext (
      .clk   (clk),
      .rst_n (rst_n),
      .p_i   (p_q),
      .odd_i (div_q[0]),
`ifdef CLKDIV_BYPASS_EN
      .byp_i (byp_next_s),
`endif
      .clk_o (clk_o)
   );

   assign div_busy = busy_q;
   assign tick_o   = tick_q;

endmodule

// File: tb/tb_clk_divide_n.sv
// tb_clk_divide_n: randomized scoreboard bench for clk_divide_n.
// The reference model tracks periods (divisor, start time); a monitor checks
// every clk_o rise time and high time against the queued periods.
`timescale 1ns/1ps
module tb_clk_divide_n;

   localparam int DIV_W = 8;
`ifdef CLKDIV_BYPASS_EN
   localparam int BYP_N = 1;
`else
   localparam int BYP_N = 2;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             div_load;
   logic [DIV_W-1:0] div_i;
   logic             div_busy;
   logic             clk_o;
   logic             tick_o;

   typedef struct {
      int  n;
      time t;
   } period_t;

   period_t sb_q[$];
   int      n_vec  = 0;
   int      n_fail = 0;

   // Reference model state
   bit m_run;
   int m_n;
   int m_pos;
   int m_pend;
   bit m_busy;

   always #5 clk = ~clk;

   clk_divide_n #(.DIV_W(DIV_W), .DIV_INIT(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div_i    (div_i),
      .div_load (div_load),
      .div_busy (div_busy),
      .clk_o    (clk_o),
      .tick_o   (tick_o)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run  = 1'b0;
      m_n    = 3;
      m_pos  = 0;
      m_pend = 0;
      m_busy = 1'b0;
      sb_q.delete();
   endtask

   // One posedge of the ideal divider: periods of m_n cycles, loads wait for a boundary.
   task automatic model_step();
      bit boundary;
      boundary = m_run ? (m_pos == m_n - 1) : en;
      if (boundary) begin
         if (m_busy) begin
            m_n    = m_pend;
            m_busy = 1'b0;
         end
         if (en) begin
            m_run = 1'b1;
            m_pos = 0;
            sb_q.push_back('{n: m_n, t: $time});
         end else begin
            m_run = 1'b0;
         end
      end else if (m_run) begin
         m_pos++;
      end
      if (div_load && (div_i != '0)) begin
         m_pend = (div_i == 8'd1) ? BYP_N : int'(div_i);
         m_busy = 1'b1;
      end
   endtask

   // Called at posedge+2; drives inputs, advances one cycle, checks tick/busy.
   task automatic step(input bit e, input bit ld, input int d);
      en       = e;
      div_load = ld;
      div_i    = d[DIV_W-1:0];
      @(posedge clk);
      model_step();
      #1;
      check("tick_o", int'(tick_o), int'(m_run && (m_pos == 0)));
      check("div_busy", int'(div_busy), int'(m_busy));
      #1;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 0);
   endtask

   // Monitor: every clk_o rise must belong to a queued period with the right timing.
   initial begin
      time     t_r;
      period_t e;
      forever begin
         @(posedge clk_o);
         t_r = $time;
         #1;
         if (rst_n) begin
            check("rise_expected", (sb_q.size() != 0) ? 1 : 0, 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("rise_time_ns", int'(t_r), int'(e.t));
               @(negedge clk_o);
               if (rst_n) check("high_time_ns", int'($time - t_r), e.n * 5);
            end
         end
      end
   end

   initial begin
      int k;
      rst_n    = 1'b0;
      en       = 1'b1;
      div_load = 1'b0;
      div_i    = '0;
      model_reset();
      #50;
      check("reset_clk_o", int'(clk_o), 0);
      check("reset_tick_o", int'(tick_o), 0);
      check("reset_busy", int'(div_busy), 0);
      #50;
      rst_n = 1'b1;

      // Default divide-by-3
      run(10);
      // Load 4 mid-period
      step(1'b1, 1'b1, 4);
      run(14);
      // Load 5 then 7 before the boundary: 7 wins
      step(1'b1, 1'b1, 5);
      step(1'b1, 1'b1, 7);
      run(24);
      // Divide-by-5, drop enable mid-period, then restart
      step(1'b1, 1'b1, 5);
      run(12);
      step(1'b0, 1'b0, 0);
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 0);
      run(12);
      // Zero divisor is ignored
      step(1'b1, 1'b1, 0);
      run(12);
      // Divisor 1: bypass or divide-by-2
      step(1'b1, 1'b1, 1);
      run(10);
      step(1'b0, 1'b0, 0);
      run(4);
      step(1'b1, 1'b1, 6);
      run(10);

      // Asynchronous reset mid-high with a pending divisor
      k = 0;
      while (!(m_run && (m_pos == 0)) && (k < 40)) begin
         step(1'b1, 1'b0, 0);
         k++;
      end
      check("period_start_found", int'(k < 40), 1);
      step(1'b1, 1'b1, 9);
      check("mid_high_clk_o", int'(clk_o), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_clk_o", int'(clk_o), 0);
      check("async_rst_tick_o", int'(tick_o), 0);
      check("async_rst_busy", int'(div_busy), 0);
      model_reset();
      rst_n = 1'b1;
      run(12);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
              int'($urandom_range(0, 10)));
      end

      // Drain: stop and make sure every predicted period appeared
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 0);
      check("periods_outstanding", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_divide_n.md
# clk_divide_n

Parametrised integer clock divider producing a 50 % duty-cycle output for any divisor from 2 to 2^DIV_W−1, odd or even. It succeeds the fixed divide-by-3 block. It adds a runtime-programmable divisor applied glitch-free at period boundaries, an enable with clean stop/start, and a period-start tick. It sits in the clocking area and feeds derived clocks to downstream logic.

## Interface
- DIV_W, 8, width of divisor input and internal counter
- DIV_INIT, 3, divisor active out of reset; must be ≥2
- clk  input  1  source clock; all logic posedge except odd-extension flop (negedge)
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable, sampled on posedge clk
- div_i  input  DIV_W  new divisor value, valid with div_load
- div_load  input  1  one-cycle request to load div_i
- div_busy  output  1  a loaded divisor is pending, not yet applied
- clk_o  output  1  divided clock
- tick_o  output  1  one-clk-cycle pulse marking the start of each clk_o period

One clock; reset is asynchronous and active-low (ports clk and rst_n).

## Operation
- Reset values: cnt=0, active divisor N=DIV_INIT, pending cleared, div_busy=0, clk_o=0, tick_o=0, p_q=0, n_q=0, running=0.
- Counter cnt runs 0..N−1 and wraps to 0. A period starts on each posedge where cnt becomes 0.
- Even N: p_q is high for cnt ∈ [0, N/2). clk_o = p_q. n_q is forced 0.
- Odd N: p_q is high for cnt ∈ [0, (N−1)/2). n_q = p_q resampled on negedge clk. clk_o = p_q | n_q. High time is exactly N/2 clk periods.
- tick_o is registered and high for the one clk cycle in which cnt==0 while running.
- Enable:
  - en=1 while stopped: the next posedge starts a period with cnt=0 and clk_o rising.
  - en=0 while running: the current period completes. At the wrap, cnt parks at 0, clk_o stays 0 and tick_o stays 0.
  - A period is never truncated.
- Divisor load:
  - div_load=1 with div_i≥2 captures div_i into pending; div_busy=1 from the next cycle.
  - Pending becomes N at the next period boundary (the wrap to 0, or the next start from stopped). div_busy clears on that same edge.
  - A load while busy overwrites pending; the last value wins.
  - A load on the same edge as a boundary goes into pending and applies at the following boundary.
- div_i=0: the load is ignored and div_busy is unchanged.
- div_i=1: handled as described under Configuration.
- Asynchronous reset mid-period forces all outputs low immediately and discards the pending divisor.

## Timing
- 10 ns clk, N=3: clk_o period 30 ns, high 15 ns. N=4: period 40 ns, high 20 ns.
- First clk_o rise: first posedge clk after rst_n release with en=1.
- clk_o rising edge is aligned to posedge clk. For odd N, the falling edge is aligned to negedge clk.
- Load-to-apply latency is between 1 and N_old+1 cycles. The first period at the new N is complete; there is no runt pulse or glitch.
- tick_o rises on the same posedge as clk_o.

## Configuration
- CLKDIV_BYPASS_EN defined:
  - div_i=1 is legal. With N=1, clk_o = clk AND byp_q.
  - byp_q is updated on negedge clk at a boundary, so clk_o switches glitch-free.
  - tick_o is high every cycle while running.
- CLKDIV_BYPASS_EN undefined: div_i=1 loads as 2, and the bypass logic is absent.

## Structure
- Package clk_div_pkg holds:
  - default DIV_W
  - a divisor-clamp function (0→reject, 1→2 or bypass)
  - a half-period function returning N/2 or (N−1)/2
- Sub-module clk_div_oddext contains the negedge n_q flop and the OR/gating output stage. It keeps all negedge logic isolated. The top holds the counter, enable, pending/busy logic and tick.

## Test plan
- Reset release at 100 ns, en=1, DIV_INIT=3 → clk_o period 30 ns, high 15 ns. First rise at the first posedge after release. tick_o every 3rd cycle.
- Load div_i=4 mid-period → div_busy=1 until the wrap. The next period is 40 ns with 20 ns high, with no runt. div_busy then 0.
- Load 5, then 7 before the boundary → 7 applied. Period 70 ns, high 35 ns.
- Drop en mid-period (N=5) → the period completes, then clk_o=0 and tick_o=0. Raise en → clk_o rises on the next posedge.
- div_i=0 load → ignored, div_busy stays 0, N unchanged. Assert rst_n=0 mid-high → clk_o=0 immediately and the pending divisor is lost.
- With CLKDIV_BYPASS_EN, load 1 → clk_o equals clk from the boundary, glitch-free. Without the macro, load 1 → period 20 ns.
